// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator/checker pair:
// checker states, default polynomial and a reference next-word function.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int unsigned            LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0]  LFSR_TAPS  = 4'b1001;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] cur,
        input logic [LFSR_WIDTH-1:0] taps
    );
        return {cur[LFSR_WIDTH-2:0], ^(cur & taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-word calculator for a Fibonacci-style LFSR:
// shift left, feed back the parity of the tapped bits into bit 0.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic [WIDTH-1:0] i_cur,
    output logic [WIDTH-1:0] o_next
);

    assign o_next = {i_cur[WIDTH-2:0], ^(i_cur & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// LFSR stream checker: self-synchronises to the generator sequence, then
// flags and counts mismatches. Define LFSR_CHK_WORDCNT_EN to add word_cnt.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 3,
    parameter int unsigned      ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
`ifdef LFSR_CHK_WORDCNT_EN
    output logic [31:0]      word_cnt,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned MW = $clog2(LOCK_CNT) + 1;
    localparam int unsigned LW = $clog2(LOSS_CNT) + 1;
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    chk_state_t       r_state, w_state;
    logic [WIDTH-1:0] r_expected, w_expected;
    logic [MW-1:0]    r_match_cnt, w_match_cnt;
    logic [LW-1:0]    r_miss_cnt, w_miss_cnt;
    logic             r_locked;
    logic             r_err, w_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [WIDTH-1:0] w_din_next, w_fly_next;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_seed (
        .i_cur  (din),
        .o_next (w_din_next)
    );

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_fly (
        .i_cur  (r_expected),
        .o_next (w_fly_next)
    );

    always_comb begin
        w_state     = r_state;
        w_expected  = r_expected;
        w_match_cnt = r_match_cnt;
        w_miss_cnt  = r_miss_cnt;
        w_err       = 1'b0;
        if (din_valid) begin
            case (r_state)
                SEARCH: begin
                    if (din != '0) begin
                        w_expected  = w_din_next;
                        w_match_cnt = '0;
                        w_state     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == r_expected) begin
                        w_expected  = w_din_next;
                        w_match_cnt = r_match_cnt + 1'b1;
                        if (r_match_cnt == LOCK_LAST) begin
                            w_state    = LOCKED;
                            w_miss_cnt = '0;
                        end
                    end else if (din == '0) begin
                        w_match_cnt = '0;
                        w_state     = SEARCH;
                    end else begin
                        // Mismatch reseeds from the received word in the same beat
                        w_expected  = w_din_next;
                        w_match_cnt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction no longer follows din once locked
                    w_expected = w_fly_next;
                    if (din == r_expected) begin
                        w_miss_cnt = '0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_cnt = r_miss_cnt + 1'b1;
                        if (r_miss_cnt == LOSS_LAST) begin
                            w_state    = SEARCH;
                            w_miss_cnt = '0;
                        end
                    end
                end
                default: w_state = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_expected  <= w_expected;
            r_match_cnt <= w_match_cnt;
            r_miss_cnt  <= w_miss_cnt;
            r_locked    <= (w_state == LOCKED);
            r_err       <= w_err;
            if (clr_err)
                r_err_cnt <= '0;
            else if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

`ifdef LFSR_CHK_WORDCNT_EN
    logic [31:0] r_word_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_word_cnt <= '0;
        else if (clr_err)
            r_word_cnt <= '0;
        else if (din_valid && (r_state == LOCKED))
            r_word_cnt <= r_word_cnt + 32'd1;
    end

    assign word_cnt = r_word_cnt;
`endif

    assign locked  = r_locked;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker (default instance plus a
// small-counter instance for saturation).
module tb_lfsr_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, din_valid, clr_err;
    logic [3:0] din;
    logic       locked, err;
    logic [7:0] err_cnt;

    logic       s_valid, s_clr;
    logic [3:0] s_din;
    logic       s_locked, s_err;
    logic [1:0] s_err_cnt;

`ifdef LFSR_CHK_WORDCNT_EN
    logic [31:0] word_cnt, s_word_cnt;
`endif

    int checks = 0;
    int passed = 0;
    int unsigned idx;

    // Hand-derived sequence for taps 1001 starting at 1
    logic [3:0] seq [15] = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5,
                             4'd11, 4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8};

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr_err   (clr_err),
        .locked    (locked),
        .err       (err),
`ifdef LFSR_CHK_WORDCNT_EN
        .word_cnt  (word_cnt),
`endif
        .err_cnt   (err_cnt)
    );

    lfsr_checker #(.ERR_W(2), .LOSS_CNT(8)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .din_valid (s_valid),
        .din       (s_din),
        .clr_err   (s_clr),
        .locked    (s_locked),
        .err       (s_err),
`ifdef LFSR_CHK_WORDCNT_EN
        .word_cnt  (s_word_cnt),
`endif
        .err_cnt   (s_err_cnt)
    );

    task automatic send(input logic [3:0] w);
        @(negedge clk);
        din_valid = 1'b1;
        din       = w;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic ssend(input logic [3:0] w, input logic clr);
        @(negedge clk);
        s_valid = 1'b1;
        s_din   = w;
        s_clr   = clr;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_clr   = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked);
        else passed++;
        checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
        else passed++;
        checks++;
        if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        else passed++;
    endtask

    task automatic test_lock;
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            checks++;
            if (locked !== (i == 4)) $display("FAIL lock_word%0d: locked=%b expected %b", i, locked, (i == 4));
            else passed++;
        end
        idx = 5;
        for (int k = 0; k < 30; k++) begin
            send(seq[idx]);
            idx = (idx + 1) % 15;
            checks++;
            if (err !== 1'b0 || locked !== 1'b1)
                $display("FAIL clean_word%0d: err=%b locked=%b expected err=0 locked=1", k, err, locked);
            else passed++;
        end
        checks++;
        if (err_cnt !== 8'd0) $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt);
        else passed++;
    endtask

    task automatic test_single_error;
        send(seq[idx]);                 // 13
        idx = (idx + 1) % 15;
        send(4'd11);                    // 10 expected
        idx = (idx + 1) % 15;
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1)
            $display("FAIL single_err: err=%b cnt=%0d locked=%b expected 1/1/1", err, err_cnt, locked);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            send(seq[idx]);             // 5, 11, 6
            idx = (idx + 1) % 15;
            checks++;
            if (err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b1)
                $display("FAIL single_resume%0d: err=%b cnt=%0d locked=%b expected 0/1/1", k, err, err_cnt, locked);
            else passed++;
        end
    endtask

    task automatic test_loss_relock;
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) $display("FAIL clr_err: got %0d expected 0", err_cnt);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            send(seq[(idx + 7) % 15]);
            idx = (idx + 1) % 15;
            checks++;
            if (err !== 1'b1 || err_cnt !== 8'(k + 1) || locked !== (k != 2))
                $display("FAIL loss_miss%0d: err=%b cnt=%0d locked=%b expected 1/%0d/%b",
                         k, err, err_cnt, locked, k + 1, (k != 2));
            else passed++;
        end
        for (int k = 0; k < 5; k++) begin
            send(seq[(13 + k) % 15]);   // 4,8,1,3,7
            checks++;
            if (locked !== (k == 4) || err !== 1'b0 || err_cnt !== 8'd3)
                $display("FAIL relock_word%0d: locked=%b err=%b cnt=%0d expected %b/0/3",
                         k, locked, err, err_cnt, (k == 4));
            else passed++;
        end
    endtask

    task automatic test_gaps;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) send(4'd0);
        checks++;
        if (locked !== 1'b0) $display("FAIL zeros_locked: got %b expected 0", locked);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            idle(2);
            checks++;
            if (locked !== (i == 4)) $display("FAIL gap_word%0d: locked=%b expected %b", i, locked, (i == 4));
            else passed++;
        end
        idx = 5;
    endtask

    task automatic test_saturation;
        int unsigned si;
        for (int i = 0; i < 5; i++) ssend(seq[i], 1'b0);
        checks++;
        if (s_locked !== 1'b1) $display("FAIL sat_lock: got %b expected 1", s_locked);
        else passed++;
        si = 5;
        for (int k = 0; k < 5; k++) begin
            ssend(seq[(si + 7) % 15], 1'b0);
            si = (si + 1) % 15;
            checks++;
            if (s_err_cnt !== ((k < 3) ? 2'(k + 1) : 2'd3) || s_err !== 1'b1 || s_locked !== 1'b1)
                $display("FAIL sat_miss%0d: cnt=%0d err=%b locked=%b expected %0d/1/1",
                         k, s_err_cnt, s_err, s_locked, (k < 3) ? k + 1 : 3);
            else passed++;
        end
        ssend(seq[(si + 7) % 15], 1'b1);
        checks++;
        if (s_err_cnt !== 2'd0 || s_err !== 1'b1)
            $display("FAIL sat_clr_wins: cnt=%0d err=%b expected 0/1", s_err_cnt, s_err);
        else passed++;
    endtask

    task automatic test_async_reset;
        send(seq[(idx + 7) % 15]);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1)
            $display("FAIL pre_rst: err=%b cnt=%0d locked=%b expected 1/1/1", err, err_cnt, locked);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL async_rst: locked=%b err=%b cnt=%0d expected 0/0/0", locked, err, err_cnt);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            checks++;
            if (locked !== (i == 4)) $display("FAIL post_rst_word%0d: locked=%b expected %b", i, locked, (i == 4));
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = '0; clr_err = 1'b0;
        s_valid = 1'b0; s_din = '0; s_clr = 1'b0;
        idx = 0;
        #12;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_lock;
        test_single_error;
        test_loss_relock;
        test_gaps;
        test_saturation;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receiving end of the LFSR pattern link: consumes the parallel WIDTH-bit word stream produced by the LFSR generator, self-synchronises to it, then flags and counts every word that deviates from the predicted sequence.
- Sits at the sink of a PRBS loopback/BIST path; the generator drives din, and the checker reports lock status and an error count.

Parameters:
- WIDTH, 4, word/LFSR width in bits.
- TAPS, 4'b1001, feedback mask. next = {cur[WIDTH-2:0], ^(cur & TAPS)}. Default period is 15: 1,3,7,15,14,13,10,5,11,6,12,9,2,4,8.
- LOCK_CNT, 4, consecutive correct predictions required to declare lock (>=1).
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock (>=1).
- ERR_W, 8, error counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- din_valid, input, 1, din carries a sequence word this cycle.
- din, input, WIDTH, received word.
- clr_err, input, 1, synchronous clear of err_cnt.
- locked, output, 1, checker is synchronised.
- err, output, 1, one-cycle pulse: the previous valid word mismatched while LOCKED.
- err_cnt, output, ERR_W, saturating count of LOCKED mismatches.

Behaviour:
- All outputs are registered. Reset (async, rst=1) sets state=SEARCH, expected=0, match/miss counters=0, locked=0, err=0, err_cnt=0. Reset mid-stream discards lock immediately.
- Cycles with din_valid=0 change nothing except err, which returns to 0. The stream may have arbitrary gaps, and prediction advances only on valid beats.
- States: SEARCH, VERIFY, LOCKED.
- SEARCH, on valid beat:
  - din==0 (LFSR lockup word): ignore and stay in SEARCH.
  - Otherwise: expected<=next(din), match_cnt<=0, go to VERIFY.
- VERIFY, on valid beat:
  - din==expected: expected<=next(din), match_cnt++. When match_cnt reaches LOCK_CNT-1 on this beat, go to LOCKED and set locked=1 on the next edge.
  - Mismatch: reseed in the same beat (expected<=next(din), match_cnt<=0) and stay in VERIFY. If din==0, go to SEARCH instead.
  - Lock latency: locked rises 1 cycle after the (LOCK_CNT+1)-th valid word, i.e. seed word plus LOCK_CNT matches.
- LOCKED, on valid beat:
  - Flywheel: expected<=next(expected) always, independent of din.
  - Match: miss_cnt<=0.
  - Mismatch: err=1 for one cycle, err_cnt++ (saturates at all-ones, never wraps), miss_cnt++.
  - When miss_cnt reaches LOSS_CNT on this beat: go to SEARCH and set locked=0 on the next edge. err still pulses for that beat.
- Errors are counted only in LOCKED. Mismatches in SEARCH/VERIFY never touch err/err_cnt.
- clr_err=1 zeroes err_cnt. If clr_err and a mismatch occur in the same cycle, clear wins (result 0).
- The sequence wraps naturally: after word 8, expect 1.

Optional Feature:
- LFSR_CHK_WORDCNT_EN
- Defined: adds output word_cnt [31:0], counting valid beats checked while LOCKED (match or mismatch). It wraps modulo 2^32, is cleared by rst and clr_err, and holds its value outside LOCKED.
- Undefined: no word_cnt port or logic, and the remaining behaviour is identical.

Decomposition:
- Shared package lfsr_pkg holds:
  - state encoding localparams (SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2);
  - the default TAPS constant 4'b1001 and WIDTH 4, shared with the generator;
  - a next-state function lfsr_next(cur, taps).
- One natural sub-module: lfsr_step, a combinational next-word calculator used for both reseed and flywheel. The FSM and counters stay in lfsr_checker.

Test Plan:
- Clean stream 1,3,7,15,14 (seed 1), back-to-back valid -> locked=1 one cycle after word 14. Continue for 30 words: err never pulses, err_cnt=0.
- Locked, one corrupted word (expected 10, send 11), then resume correctly with 5 -> single err pulse, err_cnt=1, locked stays 1 (flywheel keeps 5 as the expected word).
- Locked, send 3 consecutive wrong words -> err pulses 3 times, err_cnt=3, locked=0 after the third. Feeding 4,8,1,3,7 relocks after word 7.
- Stream of 0s, then din_valid gaps of 2 cycles between words 1,3,7,15,14 -> SEARCH ignores zeros, gaps don't break VERIFY, lock achieved.
- err_cnt forced near saturation (ERR_W=2): 5 locked mismatches with LOSS_CNT=8 -> err_cnt sticks at 3. clr_err in the same cycle as a mismatch -> 0.
- Assert rst mid-LOCKED (async, between edges) -> locked/err/err_cnt go 0 immediately. After release, 5 correct words relock.
